music_recorder: RTL and testbench
=================================

MUSIC_RECORDER -- requirements
Module: music_recorder

Interface
REQ-001 Parameter DATA_WIDTH, default 10: note code width (one-hot note bits plus octave bits).
REQ-002 Parameter DEPTH, default 192: number of note slots stored.
REQ-003 Parameter SLOT_CYCLES, default 20833333: clock cycles per slot (72 bpm x 4); counters SHALL be 25 bits.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rec_start  in  1  pulse: begin a new recording.
REQ-007 rec_stop  in  1  pulse: end the recording.
REQ-008 note_in  in  DATA_WIDTH  live note code from the keyboard decoder; 0 means silence.
REQ-009 read_en  in  1  level: play back the stored recording.
REQ-010 read_rst  in  1  pulse: rewind playback to slot 0.
REQ-011 data_out  out  DATA_WIDTH  playback note code.
REQ-012 output_ready  out  1  data_out valid.
REQ-013 recording  out  1  high while in the REC state.
REQ-014 full  out  1  high while in the FULL state.
REQ-015 count  out  8  number of slots stored.

Function
REQ-016 FSM states: IDLE, REC, FULL; encoding is free.
REQ-017 IDLE->REC on rec_start: count<=0, slot_ctr<=1, rd_ptr<=0, output_ready<=0.
REQ-018 REC: slot_ctr increments every cycle; when slot_ctr==SLOT_CYCLES, mem[count]<=note_in, count<=count+1, slot_ctr<=1.
REQ-019 REC->FULL in the same cycle as the write that makes count==DEPTH; no further writes in FULL.
REQ-020 REC->IDLE on rec_stop; count is retained; a partial slot is discarded.
REQ-021 rec_stop coinciding with a slot write: the write completes, then the FSM enters IDLE.
REQ-022 rec_start in REC or FULL restarts the recording per REQ-017; rec_start has priority over a simultaneous rec_stop.
REQ-023 Playback is allowed only in IDLE or FULL; in REC, read_en is ignored and output_ready is 0.
REQ-024 Playback with read_en=1 and rd_ptr<count: output_ready<=1, data_out<=mem[rd_ptr], rd_ctr increments; on rd_ctr==SLOT_CYCLES, rd_ctr<=1 and rd_ptr<=rd_ptr+1.
REQ-025 Playback with rd_ptr>=count or count==0: output_ready<=0 and data_out holds its value; there is no wrap-around.
REQ-026 read_en=0: output_ready, data_out, rd_ptr and rd_ctr hold.
REQ-027 read_rst (outside reset): rd_ptr<=0, rd_ctr<=1, output_ready<=0; it has priority over read_en and does not affect the recording.
REQ-028 data_out has one-cycle registered latency from the rd_ptr it reflects.

Reset
REQ-029 rst: state<=IDLE, count<=0, rd_ptr<=0, slot_ctr<=1, rd_ctr<=1, data_out<=0, output_ready<=0, recording=0, full=0.
REQ-030 rst asserted mid-recording or mid-playback aborts the operation; memory contents are undefined after reset but are never read, because count=0.

Configuration
REQ-031 Macro REC_TRIM_SILENCE_EN: when defined, slot writes in REC with note_in==0 are skipped (slot_ctr still reloads) until the first non-zero slot of the current recording. After that, silence is stored normally.
REQ-032 Without REC_TRIM_SILENCE_EN, every slot is stored, including leading silence.

Verification (SLOT_CYCLES=4, DEPTH=8)
REQ-033 Record notes 0x004,0x040,0x080 (one per slot), then rec_stop -> count=3, then read_en -> data_out sequence 0x004,0x040,0x080 with 4 cycles each, then output_ready=0.
REQ-034 Record 9 slots without rec_stop -> full=1 and recording=0 after the 8th write, count=8, and the 9th note is not stored.
REQ-035 rec_stop in the same cycle as the 2nd slot write -> count=2 and the FSM is in IDLE on the next cycle.
REQ-036 read_rst after 2 played slots -> output_ready=0 for one cycle, then playback restarts at slot 0; read_en during REC -> output_ready stays 0.
REQ-037 With REC_TRIM_SILENCE_EN, record 0,0,0x100,0 -> count=2, contents 0x100,0; without the macro -> count=4.
REQ-038 rst during REC after 3 writes -> count=0, state IDLE, and read_en gives output_ready=0.

Source files
------------

// File: rtl/music_recorder.sv
// Slot-based note recorder: samples note_in once per slot into a buffer, then plays it back slot by slot.
// Optional macro REC_TRIM_SILENCE_EN drops leading silent slots from each recording.
module music_recorder #(
    parameter int unsigned DATA_WIDTH  = 10,
    parameter int unsigned DEPTH       = 192,
    parameter int unsigned SLOT_CYCLES = 20833333
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rec_start,
    input  logic                  rec_stop,
    input  logic [DATA_WIDTH-1:0] note_in,
    input  logic                  read_en,
    input  logic                  read_rst,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  output_ready,
    output logic                  recording,
    output logic                  full,
    output logic [7:0]            count
);

    localparam int unsigned CTR_W  = 25;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CTR_W-1:0] SLOT_LAST = CTR_W'(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_REC, S_FULL} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CTR_W-1:0]       slot_ctr;
    logic [CTR_W-1:0]       rd_ctr;
    logic [CNT_W-1:0]       rd_ptr;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic slot_done;
    logic slot_wr;
    logic slot_skip;

`ifdef REC_TRIM_SILENCE_EN
    // Set once the current recording has seen its first non-silent slot.
    logic heard;

    always_ff @(posedge clk) begin
        if (rst || rec_start) begin
            heard <= 1'b0;
        end else if (slot_done && (note_in != '0)) begin
            heard <= 1'b1;
        end
    end

    assign slot_skip = (note_in == '0) && !heard;
`else
    assign slot_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus slot write strobe; rec_start restarts from any state.
    always_comb begin
        state_nxt = state;
        slot_done = 1'b0;
        slot_wr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rec_start) state_nxt = S_REC;
            end
            S_REC: begin
                slot_done = !rec_start && (slot_ctr == SLOT_LAST);
                slot_wr   = slot_done && !slot_skip;
                if (rec_start) begin
                    state_nxt = S_REC;
                end else if (slot_wr && (count == CNT_LAST)) begin
                    state_nxt = S_FULL;
                end else if (rec_stop) begin
                    state_nxt = S_IDLE;
                end
            end
            S_FULL: begin
                if (rec_start) state_nxt = S_REC;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            recording <= 1'b0;
            full      <= 1'b0;
        end else begin
            recording <= (state_nxt == S_REC);
            full      <= (state_nxt == S_FULL);
        end
    end

    // Record side: slot timer and stored-slot count.
    always_ff @(posedge clk) begin
        if (rst || rec_start) begin
            count    <= '0;
            slot_ctr <= CTR_W'(1);
        end else if (state == S_REC) begin
            if (slot_done) begin
                slot_ctr <= CTR_W'(1);
                if (slot_wr) count <= count + CNT_W'(1);
            end else begin
                slot_ctr <= slot_ctr + CTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (slot_wr) mem[ADDR_W'(count)] <= note_in;
    end

    // Playback side: one registered read per cycle, pointer advances every slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            rd_ctr       <= CTR_W'(1);
            data_out     <= '0;
            output_ready <= 1'b0;
        end else if (rec_start || read_rst) begin
            rd_ptr       <= '0;
            rd_ctr       <= CTR_W'(1);
            output_ready <= 1'b0;
        end else if (state == S_REC) begin
            output_ready <= 1'b0;
        end else if (read_en) begin
            if (rd_ptr < count) begin
                output_ready <= 1'b1;
                data_out     <= mem[ADDR_W'(rd_ptr)];
                if (rd_ctr == SLOT_LAST) begin
                    rd_ctr <= CTR_W'(1);
                    rd_ptr <= rd_ptr + CNT_W'(1);
                end else begin
                    rd_ctr <= rd_ctr + CTR_W'(1);
                end
            end else begin
                output_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_music_recorder.sv
// Directed bench for music_recorder with short slots (4 cycles) and an 8-slot buffer.
module tb_music_recorder;

    logic       clk = 1'b0;
    logic       rst;
    logic       rec_start;
    logic       rec_stop;
    logic [9:0] note_in;
    logic       read_en;
    logic       read_rst;
    logic [9:0] data_out;
    logic       output_ready;
    logic       recording;
    logic       full;
    logic [7:0] count;

    int checks   = 0;
    int failures = 0;
    int seq3[3]  = '{32'h004, 32'h040, 32'h080};
    int exp_seq[4];
    int exp_cnt;

    music_recorder #(
        .DATA_WIDTH (10),
        .DEPTH      (8),
        .SLOT_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rec_start   (rec_start),
        .rec_stop    (rec_stop),
        .note_in     (note_in),
        .read_en     (read_en),
        .read_rst    (read_rst),
        .data_out    (data_out),
        .output_ready(output_ready),
        .recording   (recording),
        .full        (full),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_rec();
        rec_start = 1'b1;
        cyc(1);
        rec_start = 1'b0;
    endtask

    task automatic stop_rec();
        rec_stop = 1'b1;
        cyc(1);
        rec_stop = 1'b0;
    endtask

    task automatic rec_slot(input logic [9:0] n);
        note_in = n;
        cyc(4);
    endtask

    initial begin
        rst = 1'b1; rec_start = 1'b0; rec_stop = 1'b0;
        note_in = '0; read_en = 1'b0; read_rst = 1'b0;
        cyc(2);
        check_eq("rst_count", 32'(count), 32'h0);
        check_eq("rst_recording", 32'(recording), 32'h0);
        check_eq("rst_full", 32'(full), 32'h0);
        check_eq("rst_ready", 32'(output_ready), 32'h0);
        check_eq("rst_data", 32'(data_out), 32'h0);
        rst = 1'b0;
        cyc(1);

        // Three notes, stop, full playback
        start_rec();
        check_eq("rec_on", 32'(recording), 32'h1);
        rec_slot(10'h004); rec_slot(10'h040); rec_slot(10'h080);
        check_eq("rec3_count", 32'(count), 32'h3);
        stop_rec();
        check_eq("stop_recording", 32'(recording), 32'h0);
        check_eq("stop_full", 32'(full), 32'h0);
        check_eq("stop_count", 32'(count), 32'h3);
        read_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            check_eq("play_data", 32'(data_out), 32'(seq3[i/4]));
            check_eq("play_ready", 32'(output_ready), 32'h1);
        end
        cyc(1);
        check_eq("play_end_ready", 32'(output_ready), 32'h0);
        check_eq("play_end_hold", 32'(data_out), 32'h080);

        // Rewind, play two slots, rewind again with read_en held
        read_rst = 1'b1; cyc(1); read_rst = 1'b0;
        check_eq("rewind_ready", 32'(output_ready), 32'h0);
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            check_eq("replay_data", 32'(data_out), 32'(seq3[i/4]));
        end
        read_rst = 1'b1; cyc(1); read_rst = 1'b0;
        check_eq("rewind2_ready", 32'(output_ready), 32'h0);
        cyc(1);
        check_eq("restart_ready", 32'(output_ready), 32'h1);
        check_eq("restart_data", 32'(data_out), 32'h004);
        read_en = 1'b0;
        cyc(3);
        check_eq("hold_ready", 32'(output_ready), 32'h1);
        check_eq("hold_data", 32'(data_out), 32'h004);

        // read_en ignored in REC; rec_stop on the 2nd slot write
        start_rec();
        note_in = 10'h004;
        read_en = 1'b1;
        cyc(2);
        check_eq("rec_read_ready", 32'(output_ready), 32'h0);
        check_eq("rec_read_recording", 32'(recording), 32'h1);
        read_en = 1'b0;
        cyc(2);
        note_in = 10'h040;
        cyc(3);
        stop_rec();
        check_eq("stopwr_count", 32'(count), 32'h2);
        check_eq("stopwr_recording", 32'(recording), 32'h0);
        check_eq("stopwr_full", 32'(full), 32'h0);
        read_en = 1'b1;
        cyc(1);
        check_eq("stopwr_d0", 32'(data_out), 32'h004);
        cyc(4);
        check_eq("stopwr_d1", 32'(data_out), 32'h040);
        cyc(4);
        check_eq("stopwr_end", 32'(output_ready), 32'h0);
        read_en = 1'b0;

        // Overfill: 9 slots into an 8-slot buffer
        start_rec();
        for (int i = 0; i < 8; i++) rec_slot(10'(i + 1));
        check_eq("full_flag", 32'(full), 32'h1);
        check_eq("full_recording", 32'(recording), 32'h0);
        check_eq("full_count", 32'(count), 32'h8);
        rec_slot(10'h3ff);
        check_eq("full_9th_count", 32'(count), 32'h8);
        read_en = 1'b1;
        cyc(1);
        check_eq("full_d0", 32'(data_out), 32'h1);
        cyc(28);
        check_eq("full_d7", 32'(data_out), 32'h8);
        check_eq("full_d7_ready", 32'(output_ready), 32'h1);
        cyc(4);
        check_eq("full_end_ready", 32'(output_ready), 32'h0);
        check_eq("full_end_hold", 32'(data_out), 32'h8);
        read_en = 1'b0;
        start_rec();
        check_eq("restart_full", 32'(full), 32'h0);
        check_eq("restart_recording", 32'(recording), 32'h1);
        check_eq("restart_count", 32'(count), 32'h0);
        stop_rec();

        // Leading silence
        start_rec();
        rec_slot(10'h000); rec_slot(10'h000); rec_slot(10'h100); rec_slot(10'h000);
        stop_rec();
`ifdef REC_TRIM_SILENCE_EN
        exp_cnt = 2;
        exp_seq = '{32'h100, 32'h000, 32'h000, 32'h000};
`else
        exp_cnt = 4;
        exp_seq = '{32'h000, 32'h000, 32'h100, 32'h000};
`endif
        check_eq("sil_count", 32'(count), 32'(exp_cnt));
        read_en = 1'b1;
        for (int k = 0; k < exp_cnt; k++) begin
            cyc((k == 0) ? 1 : 4);
            check_eq("sil_data", 32'(data_out), 32'(exp_seq[k]));
            check_eq("sil_ready", 32'(output_ready), 32'h1);
        end
        cyc(4);
        check_eq("sil_end_ready", 32'(output_ready), 32'h0);
        read_en = 1'b0;

        // Reset mid-recording
        start_rec();
        rec_slot(10'h001); rec_slot(10'h002); rec_slot(10'h003);
        cyc(2);
        check_eq("prerst_count", 32'(count), 32'h3);
        rst = 1'b1; cyc(1); rst = 1'b0;
        check_eq("midrst_count", 32'(count), 32'h0);
        check_eq("midrst_recording", 32'(recording), 32'h0);
        check_eq("midrst_full", 32'(full), 32'h0);
        read_en = 1'b1;
        cyc(2);
        check_eq("midrst_read_ready", 32'(output_ready), 32'h0);
        read_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
